// File: rtl/qspi_target.sv
// QSPI memory target: decodes single read (0x03), single write (0x02) and quad-output read (0x6B)
// from an asynchronous mode-0 bus, and drives a simple one-clk strobe memory port.
// Ports: clk/rst_n system; cs_n/sclk/io_in bus inputs; io_out/io_oe bus outputs;
//        mem_addr/mem_re/mem_rdata/mem_we/mem_wdata memory port; busy, bad_cmd status.
module qspi_target #(
  parameter int ADDR_W    = 24,
  parameter int DUMMY_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              bad_cmd
);

  // Shared bit/dummy counter; DUMMY_CYC must fit in it.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

  state_t           state;
  logic [1:0]       cs_sync, sclk_sync, sync_fill;
  logic [3:0]       io_meta, io_s;
  logic             cs_s, sclk_s, cs_prev, sclk_prev;
  logic             rise, fall, cs_fall;
  logic [CNT_W-1:0] cnt, last_slot;
  logic [22:0]      shreg;
  logic [23:0]      sh_next;
  logic             is_write, is_quad;
  logic [7:0]       obuf, dbuf, rd_src;
  logic             re_d1;
  logic             unused_io;

  assign cs_s    = cs_sync[1];
  assign sclk_s  = sclk_sync[1];
  assign rise    = sclk_s & ~sclk_prev;
  assign fall    = ~sclk_s & sclk_prev;
  assign cs_fall = cs_prev & ~cs_s;
  assign busy    = ~cs_s;
  assign sh_next = {shreg, io_s[0]};
  // Read data arrives the clk after mem_re; use it directly if the first
  // fall lands in the same clk it is being captured.
  assign rd_src    = re_d1 ? mem_rdata : dbuf;
  assign last_slot = is_quad ? CNT_W'(1) : CNT_W'(7);
  // io_in[3:1] are synchronized but no supported command samples them.
  assign unused_io = ^io_s[3:1];

  // Synchronizers and edge history. cs_prev only arms once the chain holds
  // real samples, so a cs_n held low through reset is not seen as a fresh
  // falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      io_meta   <= 4'h0;
      io_s      <= 4'h0;
      sync_fill <= 2'b00;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_sync <= {sclk_sync[0], sclk};
      io_meta   <= io_in;
      io_s      <= io_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      cs_prev   <= cs_s & sync_fill[1];
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      is_write  <= 1'b0;
      is_quad   <= 1'b0;
      obuf      <= 8'h00;
      dbuf      <= 8'h00;
      re_d1     <= 1'b0;
      io_out    <= 4'h0;
      io_oe     <= 4'h0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      bad_cmd   <= 1'b0;
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      bad_cmd <= 1'b0;
      re_d1   <= mem_re;
      if (re_d1) dbuf <= mem_rdata;
      // Write address advances the clk after each write strobe.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      if (cs_s) begin
        state  <= IDLE;
        cnt    <= '0;
        io_oe  <= 4'h0;
        io_out <= 4'h0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (rise) begin
            shreg <= sh_next[22:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt <= '0;
              case (sh_next[7:0])
                8'h03:   begin state <= ADDR; is_write <= 1'b0; is_quad <= 1'b0; end
                8'h02:   begin state <= ADDR; is_write <= 1'b1; is_quad <= 1'b0; end
                8'h6B:   begin state <= ADDR; is_write <= 1'b0; is_quad <= 1'b1; end
                default: begin state <= IGNORE; bad_cmd <= 1'b1; end
              endcase
            end
          end
          ADDR: if (rise) begin
            shreg <= sh_next[22:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(23)) begin
              cnt      <= '0;
              mem_addr <= ADDR_W'(sh_next);
              if (is_write) begin
                state <= WDATA;
              end else if (is_quad && DUMMY_CYC > 0) begin
                state <= DUMMY;
              end else begin
                state  <= RDATA;
                mem_re <= 1'b1;
                io_oe  <= is_quad ? 4'b1111 : 4'b0010;
              end
            end
          end
          DUMMY: if (rise) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DUMMY_CYC - 1)) begin
              cnt    <= '0;
              state  <= RDATA;
              mem_re <= 1'b1;
              io_oe  <= 4'b1111;
            end
          end
          RDATA: if (fall) begin
            if (cnt == '0) begin
              // First slot of a byte: load it and prefetch the next one.
              mem_re   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
              if (is_quad) begin
                io_out <= rd_src[7:4];
                obuf   <= {rd_src[3:0], 4'h0};
              end else begin
                io_out <= {2'b00, rd_src[7], 1'b0};
                obuf   <= {rd_src[6:0], 1'b0};
              end
            end else if (is_quad) begin
              io_out <= obuf[7:4];
              obuf   <= {obuf[3:0], 4'h0};
            end else begin
              io_out <= {2'b00, obuf[7], 1'b0};
              obuf   <= {obuf[6:0], 1'b0};
            end
            cnt <= (cnt == last_slot) ? '0 : cnt + CNT_W'(1);
          end
          WDATA: if (rise) begin
            shreg <= sh_next[22:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt       <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= sh_next[7:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: a bus host drives mode-0 transactions while a
// scoreboard of expected memory strobes and read data is checked as the
// target produces them.
module tb_qspi_target;
  localparam int AW = 24;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sclk = 1'b0;
  logic [3:0]    io_in = 4'h0;
  logic [3:0]    io_out, io_oe;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    mem_wdata;
  logic          busy, bad_cmd;

  logic [7:0]  mem [256];
  logic [23:0] exp_re[$];
  logic [31:0] exp_we[$];
  logic [7:0]  exp_rd[$];
  int n_chk = 0;
  int n_bad = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  qspi_target #(.ADDR_W(AW), .DUMMY_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .busy(busy), .bad_cmd(bad_cmd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Backing memory: data valid the clk after the read strobe.
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr[7:0]];

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bad_cmd) bad_cnt++;
    if (mem_re) begin
      if (exp_re.size() == 0) chk("re_unexpected", 32'(mem_re), 32'd0);
      else chk("re_addr", 32'(mem_addr), 32'(exp_re.pop_front()));
    end
    if (mem_we) begin
      if (exp_we.size() == 0) chk("we_unexpected", 32'(mem_we), 32'd0);
      else chk("we_addr_data", {mem_addr, mem_wdata}, exp_we.pop_front());
    end
  end

  // One sclk period: data set while low, sample target outputs at the rise.
  // With last set, sclk is left high so the transfer ends without a fall.
  task automatic sck(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe, input bit last);
    io_in = d;
    #60;
    sclk = 1'b1;
    q  = io_out;
    oe = io_oe;
    #60;
    if (!last) sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    logic [3:0] q, oe;
    for (int i = n - 1; i >= 0; i--) sck({3'b000, v[i]}, q, oe, 1'b0);
  endtask

  task automatic start_txn();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_high", 32'(busy), 32'd1);
  endtask

  task automatic end_txn();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_low", 32'(busy), 32'd0);
    chk("oe_idle", 32'(io_oe), 32'd0);
  endtask

  task automatic write_txn(input logic [23:0] a, input logic [15:0] d, input int nbits);
    for (int k = 0; k < nbits / 8; k++) exp_we.push_back({a + 24'(k), d[15 - 8 * k -: 8]});
    start_txn();
    send_bits(24'h02, 8);
    send_bits(a, 24);
    send_bits({8'h00, d} >> (16 - nbits), nbits);
    end_txn();
    chk("we_drain", 32'(exp_we.size()), 32'd0);
  endtask

  task automatic read_txn(input logic [23:0] a, input int n, input bit quad);
    logic [3:0] q, oe;
    logic [7:0] got, ix;
    int per;
    per = quad ? 2 : 8;
    for (int k = 0; k <= n; k++) exp_re.push_back(a + 24'(k));
    for (int k = 0; k < n; k++) begin
      ix = a[7:0] + 8'(k);
      exp_rd.push_back(mem[ix]);
    end
    start_txn();
    send_bits(quad ? 24'h6B : 24'h03, 8);
    send_bits(a, 24);
    if (quad) send_bits(24'h0, DC);
    for (int j = 0; j < n; j++) begin
      got = 8'h00;
      for (int i = 0; i < per; i++) begin
        sck(4'h0, q, oe, (j == n - 1) && (i == per - 1));
        got = quad ? {got[3:0], q} : {got[6:0], q[1]};
        if (j == 0 && i == 0) chk("rd_oe", 32'(oe), quad ? 32'hF : 32'h2);
      end
      chk("rd_byte", 32'(got), 32'(exp_rd.pop_front()));
    end
    end_txn();
    chk("re_drain", 32'(exp_re.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] q, oe;
    int b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'hFF] = 8'h5A;
    mem[8'h00] = 8'hC3;
    mem[8'h40] = 8'h12;

    repeat (3) @(negedge clk);
    chk("rst_io_out", 32'(io_out), 32'd0);
    chk("rst_io_oe", 32'(io_oe), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_status", {30'd0, busy, bad_cmd}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two-byte write, two-byte single read, quad read across the address wrap.
    write_txn(24'h000010, 16'hA53C, 16);
    read_txn(24'h000010, 2, 1'b0);
    read_txn(24'hFFFFFF, 2, 1'b1);

    // Unsupported opcode: one bad_cmd pulse, outputs stay released.
    b0 = bad_cnt;
    start_txn();
    send_bits(24'h9F, 8);
    for (int i = 0; i < 8; i++) begin
      sck(4'hF, q, oe, 1'b0);
      chk("ignore_oe", 32'(oe), 32'd0);
    end
    end_txn();
    chk("bad_pulse", 32'(bad_cnt - b0), 32'd1);

    // Partial second byte is dropped; the following write decodes normally.
    write_txn(24'h000020, 16'h5EA0, 12);
    write_txn(24'h000030, 16'h7700, 8);

    // Reset in the middle of a quad read.
    exp_re.push_back(24'h000040);
    exp_re.push_back(24'h000041);
    start_txn();
    send_bits(24'h6B, 8);
    send_bits(24'h000040, 24);
    send_bits(24'h0, DC);
    sck(4'h0, q, oe, 1'b0);
    chk("rq_nib0", 32'(q), 32'h1);
    sck(4'h0, q, oe, 1'b1);
    chk("rq_nib1", 32'(q), 32'h2);
    chk("rq_oe", 32'(oe), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 32'(io_oe), 32'd0);
    chk("rst_mid_out", 32'(io_out), 32'd0);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // cs_n still low from before reset: this must not start a transaction.
    send_bits(24'h03, 8);
    send_bits(24'h000040, 24);
    for (int i = 0; i < 4; i++) begin
      sck(4'h0, q, oe, 1'b0);
      chk("post_rst_oe", 32'(oe), 32'd0);
    end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_re_drain", 32'(exp_re.size()), 32'd0);
    write_txn(24'h000050, 16'h9900, 8);

    chk("bad_total", 32'(bad_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 Parameter ADDR_W, default 24, memory address width in bits (24 address bits always shifted on the bus; upper bits beyond ADDR_W ignored).
REQ-002 Parameter DUMMY_CYC, default 8, dummy sclk cycles for quad read.
REQ-003 clk  in  1  system clock; sclk frequency SHALL be at most clk/4.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cs_n  in  1  bus chip select, active low, asynchronous to clk.
REQ-006 sclk  in  1  bus serial clock, mode 0, asynchronous to clk.
REQ-007 io_in  in  4  bus data lines sampled from pads.
REQ-008 io_out  out  4  bus data driven to pads.
REQ-009 io_oe  out  4  per-line output enable.
REQ-010 mem_addr  out  ADDR_W  backing-memory address.
REQ-011 mem_re  out  1  one-clk read strobe; mem_rdata valid the following clk.
REQ-012 mem_rdata  in  8  read data.
REQ-013 mem_we  out  1  one-clk write strobe.
REQ-014 mem_wdata  out  8  write data, valid with mem_we.
REQ-015 busy  out  1  high while synchronized cs_n is low.
REQ-016 bad_cmd  out  1  one-clk pulse on an unsupported opcode.

Function
REQ-017 cs_n, sclk, io_in SHALL each pass a 2-flop synchronizer; sclk rise/fall SHALL be detected from synchronized samples.
REQ-018 All bus input sampling SHALL occur on detected sclk rise; all output shifting on detected sclk fall; bits MSB first.
REQ-019 States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-020 IDLE->CMD on synchronized cs_n falling; CMD collects 8 bits on io_in[0].
REQ-021 Opcodes: 0x03 single read, 0x02 single write, 0x6B quad-output read; any other -> IGNORE plus bad_cmd pulse.
REQ-022 ADDR collects 24 bits on io_in[0]; mem_addr SHALL take the low ADDR_W bits.
REQ-023 0x03: ADDR->RDATA; 0x6B: ADDR->DUMMY (DUMMY_CYC rises)->RDATA; 0x02: ADDR->WDATA.
REQ-024 Read prefetch: mem_re SHALL pulse the clk after the rise ending ADDR (0x03) or DUMMY (0x6B), and again the clk after the first bit of each byte is driven, with mem_addr incremented.
REQ-025 RDATA 0x03: io_oe=4'b0010, one bit per fall on io_out[1]; 0x6B: io_oe=4'b1111, one nibble per fall, high nibble first.
REQ-026 First read bit/nibble SHALL be driven on the first fall after entering RDATA.
REQ-027 WDATA: each 8 bits on io_in[0] SHALL produce one mem_we pulse with mem_wdata=byte, mem_addr=current address, then address increment.
REQ-028 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-029 Outside RDATA io_oe SHALL be 4'b0000; io_out don't-care but SHALL be 0.
REQ-030 Synchronized cs_n high in any state SHALL return to IDLE next clk, io_oe=0, partial write byte discarded (no mem_we), partial command/address discarded.
REQ-031 sclk edges while cs_n high SHALL be ignored.
REQ-032 mem_re and mem_we SHALL never assert in the same clk.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, io_out=0, io_oe=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0, busy=0, bad_cmd=0, synchronizers to cs_n=1, sclk=0.
REQ-034 Reset mid-transaction SHALL abort without any further memory strobe; first transaction after release requires a fresh cs_n falling edge.

Verification
REQ-035 Write 0x02, addr 0x000010, bytes 0xA5,0x3C -> mem_we twice: (0x10,0xA5),(0x11,0x3C).
REQ-036 Read 0x03, addr 0x000010, memory 0xA5,0x3C -> io_oe=0010, io_out[1] bits 10100101 00111100, mem_re at 0x10,0x11,0x12.
REQ-037 Quad read 0x6B, addr 0xFFFFFF, 8 dummy, memory[0xFFFFFF]=0x5A, [0]=0xC3 -> nibbles 5,A,C,3 on io_out, address wraps to 0.
REQ-038 Opcode 0x9F -> one bad_cmd pulse, no mem strobes, io_oe=0 until cs_n high.
REQ-039 Write with cs_n raised after 12 data bits -> exactly one mem_we; next transaction decodes normally.
REQ-040 rst_n asserted mid quad read -> io_oe=0 immediately, no mem_re thereafter.
